cnn1d_frame_tx: RTL and testbench
=================================

CNN1D_FRAME_TX -- requirements
Module: cnn1d_frame_tx

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: sample width, signed fixed point, passed through unmodified.
REQ-002 The block SHALL have parameter FRAME_LEN, default 254: samples per frame (POOL_SIZE+FILTER_SIZE-1), legal range 2..FIFO_DEPTH.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 256: buffer depth, power of two.
REQ-004 The block SHALL have parameter GAP_CYCLES, default 4: idle cycles forced between frames, 0 allowed.
REQ-005 Ports SHALL be: clk in 1 clock; rst in 1 reset, synchronous, active-high; enable in 1 permits frame starts; s_valid in 1 upstream sample valid; s_ready out 1 upstream ready; s_data in DATA_WIDTH upstream sample; m_valid out 1 sample valid toward CNN input; m_ready in 1 CNN ready_in; m_data out DATA_WIDTH sample toward CNN; m_last out 1 final sample of frame; busy out 1 frame in progress or gap; frame_count out 16 completed frames; overflow_count out 16 dropped samples.

Function
REQ-006 Upstream transfer SHALL occur when s_valid && s_ready; the sample is written to the FIFO that cycle.
REQ-007 Downstream transfer SHALL occur when m_valid && m_ready; m_data SHALL be the FIFO head (show-ahead), popped on transfer.
REQ-008 A written sample SHALL be visible in the FIFO occupancy the cycle after the write (1-cycle write-to-read latency).
REQ-009 FSM states SHALL be IDLE, SEND, GAP.
REQ-010 IDLE -> SEND SHALL occur when enable=1 and occupancy >= FRAME_LEN; m_valid is 0 in IDLE.
REQ-011 In SEND, m_valid SHALL equal FIFO-not-empty; m_last SHALL be 1 when the sample index equals FRAME_LEN-1.
REQ-012 The sample index SHALL reset to 0 on entering SEND and increment per downstream transfer.
REQ-013 On the m_last transfer, the FSM SHALL go to GAP if GAP_CYCLES>0, otherwise to IDLE, and frame_count SHALL increment, wrapping 0xFFFF -> 0.
REQ-014 GAP SHALL last exactly GAP_CYCLES cycles with m_valid=0, then go to IDLE.
REQ-015 Deasserting enable during SEND or GAP SHALL NOT abort the frame; it only blocks the next IDLE -> SEND.
REQ-016 m_valid, m_data and m_last SHALL remain stable while m_valid=1 and m_ready=0.
REQ-017 busy SHALL be 1 in SEND and GAP and 0 in IDLE.
REQ-018 Simultaneous push and pop SHALL leave occupancy unchanged; s_ready SHALL be derived from the full flag only, with no pop lookahead.

Reset
REQ-019 While rst=1, the FSM SHALL be IDLE, the FIFO empty, the sample index 0, and m_valid=0, m_last=0, busy=0, frame_count=0, overflow_count=0, s_ready=0.
REQ-020 Reset asserted mid-frame SHALL discard all buffered samples; no partial frame resumes after reset.
REQ-021 s_ready SHALL be 1 from the first cycle after rst deasserts when the FIFO is not full.

Configuration
REQ-022 With macro CNN1D_FRAME_TX_DROP_EN defined, s_ready SHALL be held 1 outside reset; a sample offered while the FIFO is full SHALL be discarded and overflow_count SHALL increment, saturating at 0xFFFF.
REQ-023 Without CNN1D_FRAME_TX_DROP_EN, s_ready SHALL be !full (backpressure), no sample SHALL ever be dropped, and overflow_count SHALL be constant 0.

Structure
REQ-024 The FSM state enum (IDLE, SEND, GAP) SHALL be declared in the shared package cnn1d_pkg as cnn1d_tx_state_t.
REQ-025 Buffering SHALL be a sub-module cnn1d_sync_fifo (show-ahead, parameters DATA_WIDTH and DEPTH, outputs full, empty and count).

Verification (FRAME_LEN=4, FIFO_DEPTH=8, GAP_CYCLES=2, DATA_WIDTH=32)
REQ-026 Push samples 1..4, enable=1, m_ready=1 -> m_data 1,2,3,4 on consecutive cycles, m_last only with 4, frame_count=1, then 2 cycles of m_valid=0 with busy=1, then busy=0.
REQ-027 Push 3 samples, enable=1 -> m_valid stays 0; push a 4th -> SEND entered the next cycle.
REQ-028 During a frame, m_ready toggles 1,0,0,1,... -> each sample is held stable while stalled; sequence order is preserved; no duplicates or loss.
REQ-029 Push 10 samples with m_ready=0 -> without the macro, s_ready=0 after 8 and overflow_count=0; with CNN1D_FRAME_TX_DROP_EN, samples 9 and 10 are dropped and overflow_count=2.
REQ-030 rst pulse after the 2nd sample of a frame -> m_valid=0, FIFO empty, frame_count=0; a fresh 4-sample push produces a clean frame starting from the new data.
REQ-031 enable dropped after the 1st transfer with 8 samples buffered -> the frame completes with 4 samples, and no second frame starts until enable=1.

Source files
------------

// File: rtl/cnn1d_pkg.sv
// rtl/cnn1d_pkg.sv - shared types for the 1-D CNN frame transmitter
package cnn1d_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } cnn1d_tx_state_t;

endpackage

// File: rtl/cnn1d_sync_fifo.sv
// rtl/cnn1d_sync_fifo.sv - show-ahead synchronous FIFO, head visible on rd_data
module cnn1d_sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    input  logic                       rd_en,
    output logic [DATA_WIDTH-1:0]      rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  push, pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/cnn1d_frame_tx.sv
// rtl/cnn1d_frame_tx.sv - buffers samples and releases whole frames to the CNN input
// Optional overflow-drop mode: CNN1D_FRAME_TX_DROP_EN.
module cnn1d_frame_tx
    import cnn1d_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FRAME_LEN  = 254,
    parameter int FIFO_DEPTH = 256,
    parameter int GAP_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic [15:0]           frame_count,
    output logic [15:0]           overflow_count
);
    localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int IDX_W    = $clog2(FRAME_LEN);
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    cnn1d_tx_state_t  state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [15:0]      frame_count_q, frame_count_d;

    logic             fifo_wr, fifo_full, fifo_empty, pop;
    logic [CNT_W-1:0] fifo_count;

    cnn1d_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_wr),
        .wr_data (s_data),
        .rd_en   (pop),
        .rd_data (m_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

`ifdef CNN1D_FRAME_TX_DROP_EN
    logic [15:0] overflow_q, overflow_d;

    // Always ready; a sample arriving on a full buffer is counted and lost.
    assign s_ready        = !rst;
    assign fifo_wr        = s_valid && !rst && !fifo_full;
    assign overflow_count = overflow_q;

    always_comb begin
        overflow_d = overflow_q;
        if (s_valid && fifo_full && overflow_q != 16'hFFFF)
            overflow_d = overflow_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) overflow_q <= '0;
        else     overflow_q <= overflow_d;
    end
`else
    assign s_ready        = !rst && !fifo_full;
    assign fifo_wr        = s_valid && s_ready;
    assign overflow_count = '0;
`endif

    assign m_valid     = (state_q == SEND) && !fifo_empty;
    assign m_last      = (state_q == SEND) && (idx_q == IDX_W'(FRAME_LEN - 1));
    assign pop         = m_valid && m_ready;
    assign busy        = (state_q != IDLE);
    assign frame_count = frame_count_q;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        gap_d         = gap_q;
        frame_count_d = frame_count_q;
        case (state_q)
            IDLE: begin
                if (enable && fifo_count >= CNT_W'(FRAME_LEN)) begin
                    state_d = SEND;
                    idx_d   = '0;
                end
            end
            SEND: begin
                if (pop) begin
                    if (m_last) begin
                        frame_count_d = frame_count_q + 16'd1;
                        gap_d         = '0;
                        state_d       = (GAP_CYCLES > 0) ? GAP : IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_W'(GAP_LAST)) state_d = IDLE;
                else                           gap_d   = gap_q + GAP_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            gap_q         <= '0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            gap_q         <= gap_d;
            frame_count_q <= frame_count_d;
        end
    end

endmodule

// File: tb/tb_cnn1d_frame_tx.sv
// tb/tb_cnn1d_frame_tx.sv - directed checks of cnn1d_frame_tx (FRAME_LEN=4, depth 8, gap 2)
module tb_cnn1d_frame_tx;
    logic        clk = 1'b0;
    logic        rst, enable, s_valid, s_ready, m_valid, m_ready, m_last, busy;
    logic [31:0] s_data, m_data;
    logic [15:0] frame_count, overflow_count;

    int checks = 0;
    int errors = 0;

    cnn1d_frame_tx #(
        .DATA_WIDTH (32),
        .FRAME_LEN  (4),
        .FIFO_DEPTH (8),
        .GAP_CYCLES (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_last         (m_last),
        .busy           (busy),
        .frame_count    (frame_count),
        .overflow_count (overflow_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [31:0] d);
        s_valid = 1'b1;
        s_data  = d;
        step();
        s_valid = 1'b0;
    endtask

    initial begin
        int  e, n;
        logic prev_stall, fire;
        logic [31:0] prev_data;

        rst = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        step(); step();
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        check("rst_overflow", 32'(overflow_count), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("s_ready_after_rst", 32'(s_ready), 32'd1);

        // Basic frame 1..4 with continuous ready, then the two-cycle gap
        enable = 1'b1; m_ready = 1'b1;
        for (int i = 1; i <= 4; i++) push(32'(i));
        check("basic_idle_before_send", 32'(m_valid), 32'd0);
        step();
        for (int k = 1; k <= 4; k++) begin
            check("basic_m_valid", 32'(m_valid), 32'd1);
            check("basic_m_data", m_data, 32'(k));
            check("basic_m_last", 32'(m_last), 32'(k == 4));
            step();
        end
        check("basic_frame_count", 32'(frame_count), 32'd1);
        check("gap1_m_valid", 32'(m_valid), 32'd0);
        check("gap1_busy", 32'(busy), 32'd1);
        step();
        check("gap2_m_valid", 32'(m_valid), 32'd0);
        check("gap2_busy", 32'(busy), 32'd1);
        step();
        check("after_gap_busy", 32'(busy), 32'd0);

        // Three samples are not a frame; the fourth starts SEND one cycle later
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(32'h10 + 32'(i));
        step();
        check("partial_m_valid", 32'(m_valid), 32'd0);
        check("partial_busy", 32'(busy), 32'd0);
        push(32'h13);
        check("fourth_push_still_idle", 32'(m_valid), 32'd0);
        step();
        check("fourth_push_send", 32'(m_valid), 32'd1);
        check("fourth_push_busy", 32'(busy), 32'd1);

        // Stalls: ready pattern 1,0,0 repeating; held samples must not change
        e = 0; prev_stall = 1'b0; prev_data = '0;
        for (int c = 0; c < 40 && e < 4; c++) begin
            m_ready = (c % 3 == 0);
            if (prev_stall) begin
                check("stall_hold_valid", 32'(m_valid), 32'd1);
                check("stall_hold_data", m_data, prev_data);
            end
            if (m_valid) begin
                check("stall_m_data", m_data, 32'h10 + 32'(e));
                check("stall_m_last", 32'(m_last), 32'(e == 3));
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            fire       = m_valid && m_ready;
            step();
            if (fire) e++;
        end
        check("stall_transfers", 32'(e), 32'd4);
        check("stall_frame_count", 32'(frame_count), 32'd2);
        m_ready = 1'b1;
        step(); step(); step();
        check("stall_back_idle", 32'(busy), 32'd0);

        // enable low holds frames back; dropping it mid-frame does not abort
        enable = 1'b0;
        for (int i = 0; i < 8; i++) push(32'h20 + 32'(i));
        check("full_s_ready", 32'(s_ready), 32'(0));
`ifdef CNN1D_FRAME_TX_DROP_EN
        checks--;
        check("full_s_ready_drop", 32'(s_ready), 32'd1);
`endif
        step();
        check("disabled_no_send", 32'(m_valid), 32'd0);
        enable = 1'b1;
        step();
        check("en_first_data", m_data, 32'h20);
        step();
        enable = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            check("en_drop_m_data", m_data, 32'h20 + 32'(k));
            check("en_drop_m_last", 32'(m_last), 32'(k == 3));
            step();
        end
        for (int i = 0; i < 6; i++) step();
        check("en_drop_no_second_valid", 32'(m_valid), 32'd0);
        check("en_drop_no_second_busy", 32'(busy), 32'd0);
        check("en_drop_frame_count", 32'(frame_count), 32'd3);
        enable = 1'b1;
        step();
        check("reenable_m_valid", 32'(m_valid), 32'd1);
        check("reenable_m_data", m_data, 32'h24);
        for (int i = 0; i < 7; i++) step();
        check("reenable_frame_count", 32'(frame_count), 32'd4);

        // Ten offers into an 8-deep buffer with the CNN stalled
        enable = 1'b0; m_ready = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_data = 32'h30 + 32'(i);
            step();
        end
        s_valid = 1'b0;
`ifdef CNN1D_FRAME_TX_DROP_EN
        check("ovf_s_ready", 32'(s_ready), 32'd1);
        check("ovf_count", 32'(overflow_count), 32'd2);
`else
        check("ovf_s_ready", 32'(s_ready), 32'd0);
        check("ovf_count", 32'(overflow_count), 32'd0);
`endif
        enable = 1'b1; m_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 60 && n < 8; c++) begin
            if (m_valid) begin
                check("ovf_drain_data", m_data, 32'h30 + 32'(n));
                n++;
            end
            step();
        end
        check("ovf_drain_total", 32'(n), 32'd8);
        step(); step(); step(); step();
        check("ovf_frame_count", 32'(frame_count), 32'd6);
        check("ovf_idle", 32'(busy), 32'd0);

        // Reset after two transfers discards the partial frame
        for (int i = 0; i < 4; i++) push(32'h40 + 32'(i));
        step(); step(); step();
        check("pre_rst_m_data", m_data, 32'h42);
        rst = 1'b1;
        step();
        check("midrst_m_valid", 32'(m_valid), 32'd0);
        check("midrst_m_last", 32'(m_last), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_frame_count", 32'(frame_count), 32'd0);
        check("midrst_s_ready", 32'(s_ready), 32'd0);
        rst = 1'b0;
        step(); step();
        check("postrst_empty", 32'(m_valid), 32'd0);
        check("postrst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) push(32'h50 + 32'(i));
        step();
        for (int k = 0; k < 4; k++) begin
            check("postrst_m_valid", 32'(m_valid), 32'd1);
            check("postrst_m_data", m_data, 32'h50 + 32'(k));
            check("postrst_m_last", 32'(m_last), 32'(k == 3));
            step();
        end
        check("postrst_frame_count", 32'(frame_count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
